pc_update_unit: RTL and testbench



---
 rtl/pc_update_unit.sv | 121 ++++++++++++
 tb/tb_pc_update_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// Program-counter register with branch qualification and a multi-cycle exception-entry
// sequence (save EPC, fetch handler byte, load PC). Optional macro: PC_ALIGN_CHECK_EN.
module pc_update_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [7:0]  VEC_BASE   = 8'd253,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  output logic        vec_req,
  output logic [7:0]  vec_addr,
  input  logic        vec_ack,
  input  logic [7:0]  vec_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        busy
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  typedef enum logic [1:0] {IDLE, SAVE, REQ, LOAD} state_t;

  state_t      state, state_nxt;
  logic        cond_true;
  logic        ld;
  logic        exc_take;
  logic        pc_ld_idle;
  logic [7:0]  vec_byte;

  function automatic logic branch_cond(input logic [1:0] op, input logic z, input logic gt);
    case (op)
      2'b00:   return z;
      2'b01:   return !z;
      2'b10:   return !gt;
      default: return gt;
    endcase
  endfunction

  // Reserved cause 3 is folded onto the invalid-opcode handler.
  function automatic logic [1:0] fold_cause(input logic [1:0] c);
    return (c == 2'd3) ? 2'd0 : c;
  endfunction

  function automatic logic [31:0] pc_load_value(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    return {v[31:2], 2'b00};
`else
    return v;
`endif
  endfunction

  assign cond_true = branch_cond(branch_op, alu_zero, alu_gt);
  assign ld        = pc_write | (pc_write_cond & cond_true);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Exception request outranks a same-cycle PC load; neither is seen outside IDLE.
  always_comb begin
    state_nxt  = state;
    exc_take   = 1'b0;
    pc_ld_idle = 1'b0;
    case (state)
      IDLE: begin
        if (exc_req) begin
          state_nxt = SAVE;
          exc_take  = 1'b1;
        end else if (ld) begin
          pc_ld_idle = 1'b1;
        end
      end
      SAVE:    state_nxt = REQ;
      REQ:     if (vec_ack) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_RESET;
      epc       <= 32'd0;
      cause     <= 2'd0;
      vec_req   <= 1'b0;
      vec_addr  <= 8'd0;
      busy      <= 1'b0;
      vec_byte  <= 8'd0;
`ifdef PC_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      busy    <= (state_nxt != IDLE);
      vec_req <= (state_nxt == REQ);
      if (exc_take) cause <= fold_cause(exc_cause);
      if (state == SAVE) begin
        epc      <= pc - EPC_OFFSET;
        vec_addr <= VEC_BASE + {6'd0, cause};
      end
      if (state == REQ && vec_ack) vec_byte <= vec_data;
      if (state == LOAD)   pc <= {24'd0, vec_byte};
      else if (pc_ld_idle) pc <= pc_load_value(pc_next);
`ifdef PC_ALIGN_CHECK_EN
      align_err <= pc_ld_idle && (pc_next[1:0] != 2'b00);
`endif
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: stimulus pushes per-cycle expectations into a
// queue, a monitor pops and compares one entry after each rising edge.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_next = 32'd0;
  logic        pc_write = 1'b0;
  logic        pc_write_cond = 1'b0;
  logic [1:0]  branch_op = 2'b00;
  logic        alu_zero = 1'b0;
  logic        alu_gt = 1'b0;
  logic        exc_req = 1'b0;
  logic [1:0]  exc_cause = 2'd0;
  logic        vec_req;
  logic [7:0]  vec_addr;
  logic        vec_ack = 1'b0;
  logic [7:0]  vec_data = 8'd0;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        busy;
  logic        aerr_dut;

  int checks = 0;
  int failures = 0;

  pc_update_unit dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .exc_req(exc_req), .exc_cause(exc_cause), .vec_req(vec_req),
    .vec_addr(vec_addr), .vec_ack(vec_ack), .vec_data(vec_data), .pc(pc), .epc(epc),
    .cause(cause), .busy(busy)
`ifdef PC_ALIGN_CHECK_EN
    , .align_err(aerr_dut)
`endif
  );

`ifndef PC_ALIGN_CHECK_EN
  assign aerr_dut = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        vreq;
    logic [7:0]  vaddr;
    logic        busy;
    logic        aerr;
  } exp_t;

  exp_t sb[$];

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || epc !== e.epc || cause !== e.cause || vec_req !== e.vreq ||
          vec_addr !== e.vaddr || busy !== e.busy || aerr_dut !== e.aerr) begin
        failures++;
        $display("FAIL %s: got pc=%h epc=%h cause=%0d vreq=%b vaddr=%0d busy=%b aerr=%b; expected pc=%h epc=%h cause=%0d vreq=%b vaddr=%0d busy=%b aerr=%b",
                 e.name, pc, epc, cause, vec_req, vec_addr, busy, aerr_dut,
                 e.pc, e.epc, e.cause, e.vreq, e.vaddr, e.busy, e.aerr);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic pw, input logic pwc,
                      input logic [1:0] bop, input logic z, input logic gt,
                      input logic exc, input logic [1:0] ec, input logic ack,
                      input logic [7:0] vd, input logic [31:0] pcn,
                      input logic [31:0] x_pc, input logic [31:0] x_epc, input logic [1:0] x_cause,
                      input logic x_vreq, input logic [7:0] x_vaddr, input logic x_busy,
                      input logic x_aerr);
    exp_t e;
    @(negedge clk);
    reset = rst; pc_write = pw; pc_write_cond = pwc; branch_op = bop;
    alu_zero = z; alu_gt = gt; exc_req = exc; exc_cause = ec;
    vec_ack = ack; vec_data = vd; pc_next = pcn;
    e.name = name; e.pc = x_pc; e.epc = x_epc; e.cause = x_cause;
    e.vreq = x_vreq; e.vaddr = x_vaddr; e.busy = x_busy; e.aerr = x_aerr;
    sb.push_back(e);
  endtask

  initial begin
    //   name          rst pw pwc bop  z  gt exc ec   ack vd     pc_next        pc             epc            cause vrq vaddr  busy aerr
    step("reset0",     1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h0,         32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("reset1",     1, 1, 0, 2'd0, 0, 0, 1, 2'd1, 1, 8'h00, 32'h88,        32'h0,         32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("pw_10",      0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h10,        32'h10,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("beq_take",   0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 0, 8'h00, 32'h40,        32'h40,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("beq_skip",   0, 0, 1, 2'd0, 0, 1, 0, 2'd0, 0, 8'h00, 32'h80,        32'h40,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("bne_take",   0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 0, 8'h00, 32'h44,        32'h44,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("bne_skip",   0, 0, 1, 2'd1, 1, 0, 0, 2'd0, 0, 8'h00, 32'h48,        32'h44,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("ble_take",   0, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 8'h00, 32'h50,        32'h50,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("ble_skip",   0, 0, 1, 2'd2, 1, 1, 0, 2'd0, 0, 8'h00, 32'h54,        32'h50,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("bgt_take",   0, 0, 1, 2'd3, 0, 1, 0, 2'd0, 0, 8'h00, 32'h60,        32'h60,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("bgt_skip",   0, 0, 1, 2'd3, 1, 0, 0, 2'd0, 0, 8'h00, 32'h64,        32'h60,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("no_write",   0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 0, 8'h00, 32'h99,        32'h60,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("pw_24",      0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h24,        32'h24,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("exc_ovf",    0, 1, 0, 2'd0, 0, 0, 1, 2'd1, 0, 8'h00, 32'h100,       32'h24,        32'h0,         2'd1, 0, 8'd0,   1, 0);
    step("save_busy",  0, 1, 0, 2'd0, 0, 0, 1, 2'd2, 0, 8'h00, 32'h200,       32'h24,        32'h20,        2'd1, 1, 8'd254, 1, 0);
    step("req_wait",   0, 1, 1, 2'd0, 1, 0, 1, 2'd2, 0, 8'h00, 32'h300,       32'h24,        32'h20,        2'd1, 1, 8'd254, 1, 0);
    step("req_ack",    0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 8'h7C, 32'h0,         32'h24,        32'h20,        2'd1, 0, 8'd254, 1, 0);
    step("load_7c",    0, 1, 0, 2'd0, 0, 0, 1, 2'd2, 1, 8'h11, 32'h400,       32'h7C,        32'h20,        2'd1, 0, 8'd254, 0, 0);
    step("late_ack",   0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 8'h22, 32'h0,         32'h7C,        32'h20,        2'd1, 0, 8'd254, 0, 0);
    step("pw_0",       0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h0,         32'h20,        2'd1, 0, 8'd254, 0, 0);
    step("exc_rsvd",   0, 0, 0, 2'd0, 0, 0, 1, 2'd3, 0, 8'h00, 32'h0,         32'h0,         32'h20,        2'd0, 0, 8'd254, 1, 0);
    step("save_wrap",  0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h0,         32'hFFFF_FFFC, 2'd0, 1, 8'd253, 1, 0);
    step("req_hold",   0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h0,         32'hFFFF_FFFC, 2'd0, 1, 8'd253, 1, 0);
    step("rst_in_req", 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 8'h55, 32'h0,         32'h0,         32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("post_rst",   0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 8'h33, 32'h0,         32'h0,         32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("pw_30",      0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h30,        32'h30,        32'h0,         2'd0, 0, 8'd0,   0, 0);
    step("exc_div0",   0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 0, 8'h00, 32'h0,         32'h30,        32'h0,         2'd2, 0, 8'd0,   1, 0);
    step("save_div0",  0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h30,        32'h2C,        2'd2, 1, 8'd255, 1, 0);
    step("req_imm",    0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 8'hF0, 32'h0,         32'h30,        32'h2C,        2'd2, 0, 8'd255, 1, 0);
    step("load_f0",    0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'hF0,        32'h2C,        2'd2, 0, 8'd255, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    step("pw_unalign", 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h13,        32'h10,        32'h2C,        2'd2, 0, 8'd255, 0, 1);
    step("aerr_clear", 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h10,        32'h2C,        2'd2, 0, 8'd255, 0, 0);
`else
    step("pw_unalign", 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h13,        32'h13,        32'h2C,        2'd2, 0, 8'd255, 0, 0);
    step("after_13",   0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 8'h00, 32'h0,         32'h13,        32'h2C,        2'd2, 0, 8'd255, 0, 0);
`endif
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected pending=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
